// File: rtl/rr_mask_arbiter.sv
// Round-robin arbiter with a registered thermometer priority mask and a per-owner
// hold limit. One-cycle request-to-grant latency; handover happens without an idle bubble.
module rr_mask_arbiter #(
  parameter int N        = 5,
  parameter int HOLD_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N-1:0]                  req,
  output logic [N-1:0]                  grant,
  output logic                          grant_valid,
  output logic [$clog2(N)-1:0]          grant_id,
  output logic [N-1:0]                  mask,
  output logic                          dbg_state,
  output logic [$clog2(HOLD_MAX+1)-1:0] dbg_hold_cnt,
  output logic [$clog2(N)-1:0]          dbg_last_id
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [IW-1:0] LAST_RST  = IW'(N - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [IW-1:0]   last_id;
  logic [N-1:0]    masked;
  logic [IW-1:0]   win_id;
  logic            has_win;
  logic            owner_req;
  logic            release_now;
  logic            load;
  logic            drop;

  function automatic logic [N-1:0] thermo(input logic [IW-1:0] id);
    logic [N-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) t[i] = (i > int'(id));
    return t;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] id);
    logic [N-1:0] t;
    t = '0;
    t[id] = 1'b1;
    return t;
  endfunction

  // Masked candidates override the unmasked fallback; masked is a subset of req.
  always_comb begin
    masked  = req & mask;
    has_win = |req;
    win_id  = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) win_id = IW'(i);
    for (int i = N - 1; i >= 0; i--) if (masked[i]) win_id = IW'(i);
  end

  always_comb begin
    owner_req   = req[grant_id];
    release_now = (state == GRANT) && (!owner_req || (hold_cnt == HOLD_LAST));
    load        = has_win && ((state == IDLE) || release_now);
    drop        = release_now && !has_win;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      hold_cnt    <= '0;
      last_id     <= LAST_RST;
      mask        <= '0;
    end else if (load) begin
      state       <= GRANT;
      grant       <= onehot(win_id);
      grant_valid <= 1'b1;
      grant_id    <= win_id;
      hold_cnt    <= '0;
      last_id     <= win_id;
      mask        <= thermo(win_id);
    end else if (drop) begin
      // last_id and mask keep the priority history across the idle period.
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      hold_cnt    <= '0;
    end else if (state == GRANT) begin
      hold_cnt    <= hold_cnt + HOLD_ONE;
    end
  end

  assign dbg_state    = state;
  assign dbg_hold_cnt = hold_cnt;
  assign dbg_last_id  = last_id;

endmodule

// File: tb/tb_rr_mask_arbiter.sv
// Directed bench for rr_mask_arbiter (N=5, HOLD_MAX=4); expected outputs are queued
// per driven cycle and popped after the following rising edge.
module tb_rr_mask_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] grant;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic [4:0] mask;
  logic       dbg_state;
  logic [2:0] dbg_hold_cnt;
  logic [2:0] dbg_last_id;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          compared;
  int          mismatched;
  logic [4:0]  rr_mask [5];

  rr_mask_arbiter #(.N(5), .HOLD_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .mask         (mask),
    .dbg_state    (dbg_state),
    .dbg_hold_cnt (dbg_hold_cnt),
    .dbg_last_id  (dbg_last_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".grant"}, 16'(grant), 16'h0);
    check({tag, ".valid"}, 16'(grant_valid), 16'h0);
    check({tag, ".id"},    16'(grant_id), 16'h0);
    check({tag, ".mask"},  16'(mask), 16'h0);
    check({tag, ".hold"},  16'(dbg_hold_cnt), 16'h0);
    check({tag, ".last"},  16'(dbg_last_id), 16'd4);
  endtask

  // driver: apply req, queue the expected post-edge outputs, then score them
  task automatic step(input string tag, input logic [4:0] r, input logic [4:0] g,
                      input logic [2:0] id, input logic [4:0] m, input logic [2:0] h);
    logic [15:0] e;
    string       t;
    req = r;
    exp_q.push_back({g, id, m, h});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".grant"}, 16'(grant), 16'(e[15:11]));
    check({t, ".id"},    16'(grant_id), 16'(e[10:8]));
    check({t, ".mask"},  16'(mask), 16'(e[7:3]));
    check({t, ".hold"},  16'(dbg_hold_cnt), 16'(e[2:0]));
    check({t, ".valid"}, 16'(grant_valid), 16'(e[15:11] != 5'b0));
    check({t, ".onehot"}, 16'($onehot0(grant)), 16'h1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rr_mask[0] = 5'b11110;
    rr_mask[1] = 5'b11100;
    rr_mask[2] = 5'b11000;
    rr_mask[3] = 5'b10000;
    rr_mask[4] = 5'b00000;
    req = 5'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // single requester: 4-cycle hold then re-grant to itself with no bubble
    step("hold0", 5'b00100, 5'b00100, 3'd2, 5'b11000, 3'd0);
    step("hold1", 5'b00100, 5'b00100, 3'd2, 5'b11000, 3'd1);
    step("hold2", 5'b00100, 5'b00100, 3'd2, 5'b11000, 3'd2);
    step("hold3", 5'b00100, 5'b00100, 3'd2, 5'b11000, 3'd3);
    step("regrant", 5'b00100, 5'b00100, 3'd2, 5'b11000, 3'd0);

    // idle return, mask retained, then a fresh request at the top index
    step("idle", 5'b00000, 5'b00000, 3'd0, 5'b11000, 3'd0);
    step("top", 5'b10000, 5'b10000, 3'd4, 5'b00000, 3'd0);
    step("idle2", 5'b00000, 5'b00000, 3'd0, 5'b00000, 3'd0);

    // wrap-around from last_id=4 to the lowest requester
    step("wrap", 5'b00011, 5'b00001, 3'd0, 5'b11110, 3'd0);
    step("idle3", 5'b00000, 5'b00000, 3'd0, 5'b11110, 3'd0);

    // early release: owner 1 drops after 2 cycles, requester 3 takes over
    step("early0", 5'b00010, 5'b00010, 3'd1, 5'b11100, 3'd0);
    step("early1", 5'b01010, 5'b00010, 3'd1, 5'b11100, 3'd1);
    step("early2", 5'b01000, 5'b01000, 3'd3, 5'b10000, 3'd0);
    step("idle4", 5'b00000, 5'b00000, 3'd0, 5'b10000, 3'd0);

    // asynchronous reset between edges while a grant is held
    step("pre_rst0", 5'b11111, 5'b10000, 3'd4, 5'b00000, 3'd0);
    step("pre_rst1", 5'b11111, 5'b10000, 3'd4, 5'b00000, 3'd1);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #1 check_all_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;

    // full load: owners 0,1,2,3,4,0 each for HOLD_MAX cycles
    for (int k = 0; k < 6; k++) begin
      for (int h = 0; h < 4; h++) begin
        logic [4:0] g;
        int         o;
        o = k % 5;
        g = 5'b00001;
        g = g << o;
        step($sformatf("rr%0d_%0d", k, h), 5'b11111, g, 3'(o), rr_mask[o], 3'(h));
      end
    end

    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: observed %0d left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rr_mask_arbiter.md
RR_MASK_ARBITER -- requirements
Module: rr_mask_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 5, giving the number of requesters (N >= 2).
REQ-002 The block SHALL have parameter HOLD_MAX, default 4, giving the maximum number of consecutive cycles one owner may hold a grant (HOLD_MAX >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; asynchronous, active-low.
REQ-005 The block SHALL have port req, input, N bits, one request line per requester, level-sensitive.
REQ-006 The block SHALL have port grant, output, N bits, the registered one-hot grant, or all-zero when idle.
REQ-007 The block SHALL have port grant_valid, output, 1 bit, high iff grant is non-zero.
REQ-008 The block SHALL have port grant_id, output, $clog2(N) bits, the index of the current owner (0 when idle).
REQ-009 The block SHALL have port mask, output, N bits, the registered thermometer priority mask: mask[i]=1 iff i > last_id.

Function
REQ-010 The block SHALL implement two states, IDLE and GRANT; all outputs SHALL be registered.
REQ-011 The winner selection SHALL be the lowest index i with req[i] & mask[i]; if none, the lowest index i with req[i]; if req is zero, there SHALL be no winner.
REQ-012 In IDLE with a winner, the next cycle SHALL be GRANT with grant = one-hot(winner), grant_id = winner, hold_cnt = 0, last_id = winner (1-cycle req-to-grant latency).
REQ-013 In IDLE with req all-zero, the block SHALL stay in IDLE with grant all-zero.
REQ-014 In GRANT, hold_cnt SHALL increment each cycle while req[grant_id]=1 and hold_cnt < HOLD_MAX-1; grant SHALL be unchanged.
REQ-015 Release SHALL occur in GRANT when req[grant_id]=0, or when hold_cnt = HOLD_MAX-1 (owner has held HOLD_MAX cycles).
REQ-016 On release with a winner, the block SHALL switch the grant to the winner on the next cycle, with no idle bubble, hold_cnt = 0, and last_id = winner.
REQ-017 On release with no winner, the next cycle SHALL be IDLE with grant = 0, grant_id = 0, and last_id retained.
REQ-018 On timeout with the owner as sole requester, the owner SHALL be re-granted (fallback pick) with hold_cnt restarted at 0.
REQ-019 A mask update SHALL occur only when last_id changes and SHALL take effect on the same edge as the new grant.
REQ-020 Requests from non-owners SHALL never pre-empt an owner before release.
REQ-021 hold_cnt SHALL be $clog2(HOLD_MAX+1) bits wide and SHALL never exceed HOLD_MAX-1.
REQ-022 grant SHALL be one-hot or zero in every cycle, and grant_valid SHALL equal |grant.

Reset
REQ-023 While rst=0, the block SHALL be in IDLE with grant=0, grant_valid=0, grant_id=0, hold_cnt=0, last_id=N-1, mask=0, asynchronously.
REQ-024 After rst rises, the first winner SHALL be the lowest-index requester (mask=0).
REQ-025 Reset asserted mid-grant SHALL drop grant immediately without waiting for a clock edge.
REQ-026 Reset SHALL NOT retain any priority history.

Verification
REQ-027 Single-requester hold: N=5, HOLD_MAX=4, req=00100 held -> grant=00100 one cycle later, held 4 cycles, re-granted to 00100 with hold_cnt back to 0, no bubble.
REQ-028 Round robin under full load: req=11111 constant -> owners 0,1,2,3,4,0 each for 4 cycles, mask sequence 11110, 11100, 11000, 10000, 00000.
REQ-029 Early release: owner 1 drops req after 2 cycles while req[3]=1 -> grant=01000 on the next edge, grant_id=3, mask=10000.
REQ-030 Wrap-around: last_id=4, req=00011 -> grant to index 0 (fallback), mask=11110.
REQ-031 Idle return: the sole owner drops req with req=0 -> grant=0, grant_valid=0 next cycle; later req=10000 -> grant=10000 after 1 cycle.
REQ-032 Asynchronous reset mid-grant: rst=0 between edges -> grant=0 and mask=0 immediately; after release with req=11111 -> grant=00001.
